// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: host debug/boot bridge decoding UART
// read/write frames into data-memory bus operations.
module uart_mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  CMD_WRITE      = 8'h57,
  parameter logic [7:0]  CMD_READ       = 8'h52,
  parameter logic [7:0]  ACK_BYTE       = 8'h4B,
  parameter logic [7:0]  NAK_BYTE       = 8'h3F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  input  logic [31:0] mem_read_data_in,
  output logic        err_pulse,
  output logic [7:0]  err_count
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS_REQ,
    BUS_OP,
    TX_LOAD,
    TX_START,
    TX_WAIT
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic          is_write;
  logic [1:0]    byte_cnt;
  logic [TW-1:0] timer;
  logic [31:0]   addr_sr;
  logic [31:0]   data_sr;
  logic [31:0]   reply;
  logic [2:0]    reply_left;
  logic          tx_first;

  logic in_frame;
  logic timeout;
  logic drop;

  assign in_frame = (state == ADDR) ||
                    (state == DATA);
  assign timeout  = in_frame && (timer == T_LAST);
  assign drop     = rx_valid && !in_frame &&
                    (state != IDLE);

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Frame decode, bus sequencing and reply transmit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      is_write         <= 1'b0;
      byte_cnt         <= '0;
      timer            <= '0;
      addr_sr          <= '0;
      data_sr          <= '0;
      reply            <= '0;
      reply_left       <= '0;
      tx_first         <= 1'b0;
      tx_data          <= '0;
      tx_start         <= 1'b0;
      bus_req          <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      err_pulse        <= 1'b0;
      err_count        <= '0;
    end else begin
      err_pulse        <= 1'b0;
      tx_start         <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      if (drop) begin
        err_pulse <= 1'b1;
        err_count <= sat_inc(err_count);
      end
      unique case (state)
        IDLE: begin
          if (rx_valid) begin
            byte_cnt <= '0;
            timer    <= '0;
            if (rx_data == CMD_WRITE ||
                rx_data == CMD_READ) begin
              is_write <= (rx_data == CMD_WRITE);
              state    <= ADDR;
            end else begin
              reply      <= {24'd0, NAK_BYTE};
              reply_left <= 3'd1;
              state      <= TX_LOAD;
              err_pulse  <= 1'b1;
              err_count  <= sat_inc(err_count);
            end
          end
        end
        ADDR: begin
          if (timeout) begin
            state     <= IDLE;
            err_pulse <= 1'b1;
            err_count <= sat_inc(err_count);
          end else if (rx_valid) begin
            timer    <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            addr_sr  <= {rx_data, addr_sr[31:8]};
            if (byte_cnt == 2'd3) begin
              if (is_write) begin
                state <= DATA;
              end else begin
                state       <= BUS_REQ;
                bus_req     <= 1'b1;
                mem_address <=
                  {rx_data, addr_sr[31:8]};
              end
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timeout) begin
            state     <= IDLE;
            err_pulse <= 1'b1;
            err_count <= sat_inc(err_count);
          end else if (rx_valid) begin
            timer    <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            data_sr  <= {rx_data, data_sr[31:8]};
            if (byte_cnt == 2'd3) begin
              state          <= BUS_REQ;
              bus_req        <= 1'b1;
              mem_address    <= addr_sr;
              mem_write_data <=
                {rx_data, data_sr[31:8]};
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        BUS_REQ: begin
          if (bus_grant) begin
            state            <= BUS_OP;
            mem_write_enable <= is_write;
            mem_read_enable  <= !is_write;
          end
        end
        BUS_OP: begin
          bus_req <= 1'b0;
          state   <= TX_LOAD;
          if (is_write) begin
            reply      <= {24'd0, ACK_BYTE};
            reply_left <= 3'd1;
          end else begin
            reply      <= mem_read_data_in;
            reply_left <= 3'd4;
          end
        end
        TX_LOAD: begin
          if (!tx_busy) begin
            tx_data    <= reply[7:0];
            reply      <= {8'd0, reply[31:8]};
            reply_left <= reply_left - 3'd1;
            tx_start   <= 1'b1;
            state      <= TX_START;
          end
        end
        TX_START: begin
          tx_first <= 1'b1;
          state    <= TX_WAIT;
        end
        TX_WAIT: begin
          if (tx_first) begin
            tx_first <= 1'b0;
          end else if (!tx_busy) begin
            state <= (reply_left != 3'd0) ?
                     TX_LOAD : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
